ball_motion: RTL and testbench

Ball physics engine for the Pong playfield. It watches the pixel generator's `BouncingObject` strobe at four probe points around the ball to detect collisions. Once per frame, at the start of vertical blanking, it updates direction and position. It drives `ballX`/`ballY` back into the pixel generator, so it closes the loop on that interface from the other end. It also runs the serve/score sequence and pulses a score event when the ball leaves the field.

---
 rtl/ball_motion.sv | 94 +++++++++
 tb/tb_ball_motion.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/ball_motion.sv
// ball_motion: Pong ball physics; samples four collision probes around the ball,
// updates direction/position once per frame at v_cnt==480 and runs serve/score sequencing.
module ball_motion #(
  parameter int SPEED  = 1,
  parameter int HOME_X = 312,
  parameter int HOME_Y = 232
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] h_cnt,
  input  logic [9:0] v_cnt,
  input  logic       valid,
  input  logic       BouncingObject,
  input  logic       serve,
  output logic [9:0] ballX,
  output logic [9:0] ballY,
  output logic       playing,
  output logic       score1_p,
  output logic       score2_p
);
  typedef enum logic [1:0] {IDLE, SERVE, PLAY} state_t;
  localparam logic [9:0] HX = 10'(HOME_X);
  localparam logic [9:0] HY = 10'(HOME_Y);
  localparam logic [9:0] SP = 10'(SPEED);
  state_t r_state;
  logic r_v480, r_x1, r_x2, r_y1, r_y2, r_dirx, r_diry;
  logic w_upd, w_hit, w_dx, w_dy, w_rexit, w_lexit;
  logic [10:0] w_h, w_v, w_x, w_y;
  assign w_h = {1'b0, h_cnt};
  assign w_v = {1'b0, v_cnt};
  assign w_x = {1'b0, ballX};
  assign w_y = {1'b0, ballY};
  // Edge of the v_cnt==480 compare, so a held counter yields a single strobe
  assign w_upd = (v_cnt == 10'd480) && !r_v480;
  assign w_hit = valid && BouncingObject;
  assign w_dx = (r_x1 && !r_x2) ? 1'b1 : (r_x2 && !r_x1) ? 1'b0 : r_dirx;
  assign w_dy = (r_y1 && !r_y2) ? 1'b1 : (r_y2 && !r_y1) ? 1'b0 : r_diry;
  assign w_rexit = w_dx && (w_x + 11'd16 + 11'(SPEED) >= 11'd640);
  assign w_lexit = !w_dx && (w_x < 11'(SPEED));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_v480   <= 1'b0;
      {r_x1, r_x2, r_y1, r_y2} <= 4'b0;
      r_dirx   <= 1'b1;
      r_diry   <= 1'b1;
      ballX    <= HX;
      ballY    <= HY;
      playing  <= 1'b0;
      score1_p <= 1'b0;
      score2_p <= 1'b0;
    end else begin
      r_v480   <= (v_cnt == 10'd480);
      score1_p <= 1'b0;
      score2_p <= 1'b0;
      if (w_upd) begin
        {r_x1, r_x2, r_y1, r_y2} <= 4'b0;
      end else if (w_hit) begin
        if (w_v == w_y + 11'd8) begin
          r_x1 <= r_x1 | (w_h == w_x);
          r_x2 <= r_x2 | (w_h == w_x + 11'd16);
        end
        if (w_h == w_x + 11'd8) begin
          r_y1 <= r_y1 | (w_v == w_y);
          r_y2 <= r_y2 | (w_v == w_y + 11'd16);
        end
      end
      case (r_state)
        IDLE: if (serve) r_state <= SERVE;
        SERVE: if (w_upd) begin
          r_state <= PLAY;
          playing <= 1'b1;
        end
        PLAY: if (w_upd) begin
          r_diry <= w_dy;
          if (w_rexit || w_lexit) begin
            score1_p <= w_rexit;
            score2_p <= w_lexit;
            ballX    <= HX;
            ballY    <= HY;
            r_dirx   <= w_lexit;
            r_state  <= IDLE;
            playing  <= 1'b0;
          end else begin
            r_dirx <= w_dx;
            ballX  <= w_dx ? ballX + SP : ballX - SP;
            ballY  <= w_dy ? ballY + SP : ballY - SP;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ball_motion.sv
// tb_ball_motion: randomized and directed checks of ball_motion against a frame-level model.
module tb_ball_motion;
  localparam int SPEED = 1;
  localparam int HX = 312;
  localparam int HY = 232;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [9:0] h_cnt = '0, v_cnt = '0;
  logic valid = 1'b0, bo = 1'b0, serve = 1'b0;
  logic [9:0] ballX, ballY;
  logic playing, score1_p, score2_p;
  int n_chk = 0, n_err = 0;
  int m_x, m_y, m_dx, m_dy, m_st, e_s1, e_s2, n_s1, n_s2;
  bit m_hit [4];
  always #5 clk = ~clk;
  ball_motion #(.SPEED(SPEED), .HOME_X(HX), .HOME_Y(HY)) dut (
    .clk(clk), .rst_n(rst_n), .h_cnt(h_cnt), .v_cnt(v_cnt), .valid(valid),
    .BouncingObject(bo), .serve(serve), .ballX(ballX), .ballY(ballY),
    .playing(playing), .score1_p(score1_p), .score2_p(score2_p)
  );
  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic clear_hits();
    foreach (m_hit[k]) m_hit[k] = 1'b0;
  endtask
  task automatic model_reset();
    m_x = HX; m_y = HY; m_dx = 1; m_dy = 1; m_st = 0; e_s1 = 0; e_s2 = 0;
    clear_hits();
  endtask
  function automatic int new_dir(input bit a, input bit b, input int d);
    return (a && !b) ? 1 : (b && !a) ? 0 : d;
  endfunction
  // m_st: 0 idle, 1 serve, 2 play
  task automatic model_upd();
    int ndx, ndy;
    e_s1 = 0; e_s2 = 0;
    if (m_st == 1) m_st = 2;
    else if (m_st == 2) begin
      ndx = new_dir(m_hit[0], m_hit[1], m_dx);
      ndy = new_dir(m_hit[2], m_hit[3], m_dy);
      m_dy = ndy;
      if (ndx == 1 && m_x + 16 + SPEED >= 640) begin
        e_s1 = 1; m_x = HX; m_y = HY; m_dx = 0; m_st = 0;
      end else if (ndx == 0 && m_x < SPEED) begin
        e_s2 = 1; m_x = HX; m_y = HY; m_dx = 1; m_st = 0;
      end else begin
        m_dx = ndx;
        m_x += ndx ? SPEED : -SPEED;
        m_y += ndy ? SPEED : -SPEED;
      end
    end
    clear_hits();
  endtask
  task automatic check_out(input string tag);
    chk({tag, ".x"}, ballX, m_x);
    chk({tag, ".y"}, ballY, m_y);
    chk({tag, ".playing"}, playing, (m_st == 2) ? 1 : 0);
    chk({tag, ".s1"}, score1_p, e_s1);
    chk({tag, ".s2"}, score2_p, e_s2);
  endtask
  task automatic frame(input bit sv);
    bit idle0;
    idle0 = (m_st == 0);
    valid = 1'b0; bo = 1'b0; v_cnt = 10'd480; serve = sv;
    tick();
    serve = 1'b0;
    model_upd();
    if (sv && idle0) m_st = 1;
    check_out("frame");
    n_s1 += e_s1; n_s2 += e_s2;
    e_s1 = 0; e_s2 = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold.x", ballX, m_x);
      chk("hold.y", ballY, m_y);
    end
    chk("hold.s1", score1_p, 0);
    chk("hold.s2", score2_p, 0);
    v_cnt = '0;
    tick();
  endtask
  task automatic probe(input int k, input bit v);
    int hx, vy;
    hx = (k == 0) ? m_x : (k == 1) ? m_x + 16 : m_x + 8;
    vy = (k < 2) ? m_y + 8 : (k == 2) ? m_y : m_y + 16;
    h_cnt = 10'(hx); v_cnt = 10'(vy); valid = v; bo = 1'b1;
    tick();
    bo = 1'b0; valid = 1'b0; h_cnt = '0; v_cnt = '0;
    if (v) m_hit[k] = 1'b1;
  endtask
  task automatic keep_y();
    if (m_y >= 400) probe(3, 1'b1);
    else if (m_y <= 40) probe(2, 1'b1);
  endtask
  task automatic do_serve();
    serve = 1'b1;
    tick();
    serve = 1'b0;
    if (m_st == 0) m_st = 1;
    chk("serve.playing", playing, 0);
  endtask
  task automatic run_until_idle();
    for (int i = 0; i < 800 && m_st == 2; i++) begin
      keep_y();
      frame(1'b0);
    end
    chk("run.playing", playing, 0);
  endtask
  initial begin
    #1000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
  initial begin
    n_s1 = 0; n_s2 = 0;
    model_reset();
    #12 rst_n = 1'b1;
    check_out("reset");
    for (int i = 0; i < 3; i++) frame(1'b0);
    do_serve();
    frame(1'b0);
    for (int i = 0; i < 10; i++) frame(1'b0);
    chk("free.x10", ballX, 322);
    chk("free.y10", ballY, 242);
    probe(1, 1'b1); frame(1'b0);
    chk("x2.x", ballX, 321);
    probe(3, 1'b1); frame(1'b0);
    chk("y2.y", ballY, 242);
    probe(0, 1'b1); probe(1, 1'b1); frame(1'b0);
    chk("both.x", ballX, 319);
    probe(0, 1'b0); frame(1'b0);
    chk("novalid.x", ballX, 318);
    probe(0, 1'b1); frame(1'b0);
    run_until_idle();
    chk("score1.count", n_s1, 1);
    frame(1'b1);
    chk("serve_upd.playing", playing, 0);
    frame(1'b0);
    run_until_idle();
    chk("score2.count", n_s2, 1);
    do_serve();
    frame(1'b0);
    for (int f = 0; f < 80; f++) begin
      if (m_st == 0 && $urandom_range(0, 3) == 0) do_serve();
      for (int k = 0; k < 2; k++)
        if ($urandom_range(0, 2) == 0) probe(k, $urandom_range(0, 3) != 0);
      if (m_y >= 400 || m_y <= 40) keep_y();
      else if ($urandom_range(0, 2) == 0) probe(2 + $urandom_range(0, 1), 1'b1);
      frame(1'b0);
    end
    if (m_st != 2) begin
      if (m_st == 0) do_serve();
      frame(1'b0);
    end
    for (int i = 0; i < 3; i++) frame(1'b0);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 model_reset();
    check_out("async_rst");
    #3 rst_n = 1'b1;
    tick();
    check_out("post_rst");
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
